// File: rtl/fdu_pkg.sv
// rtl/fdu_pkg.sv - shared types and widths for the FDU failover controller
package fdu_pkg;

  localparam int FAILOVER_CNT_W = 8;
  localparam int RETRY_CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_FAILED = 2'd3
  } fdu_state_e;

  // Failover counter stops at all-ones instead of wrapping back to zero
  function automatic logic [FAILOVER_CNT_W-1:0] sat_inc_fo(input logic [FAILOVER_CNT_W-1:0] v);
    return (v == {FAILOVER_CNT_W{1'b1}}) ? v : v + FAILOVER_CNT_W'(1);
  endfunction

endpackage

// File: rtl/fdu_lane_mon.sv
// rtl/fdu_lane_mon.sv - per-lane health debounce and restart pulse timer
module fdu_lane_mon #(
  parameter int HOLDOFF        = 16,
  parameter int RESTART_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic health,
  input  logic restart_req,
  output logic good_stable,
  output logic bad_stable,
  output logic restarting,
  output logic fdu_restart
);

  localparam int HW = $clog2(HOLDOFF + 1);
  localparam int RW = $clog2(RESTART_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLDOFF);
  localparam logic [RW-1:0] RST_LOAD = RW'(RESTART_CYCLES);

  logic [HW-1:0] good_cnt;
  logic [HW-1:0] bad_cnt;
  logic [RW-1:0] rst_timer;

  // Restart timer: a request only loads an idle timer, so a running restart is never stretched
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_timer <= '0;
    end else if (rst_timer != '0) begin
      rst_timer <= rst_timer - RW'(1);
    end else if (restart_req) begin
      rst_timer <= RST_LOAD;
    end
  end

  // Debounce: count consecutive same-level samples, saturating at HOLDOFF; frozen at zero while restarting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (restarting || restart_req) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (health) begin
      bad_cnt <= '0;
      if (good_cnt != HOLD_MAX) good_cnt <= good_cnt + HW'(1);
    end else begin
      good_cnt <= '0;
      if (bad_cnt != HOLD_MAX) bad_cnt <= bad_cnt + HW'(1);
    end
  end

  assign restarting  = (rst_timer != '0);
  assign fdu_restart = restarting;
  assign good_stable = (good_cnt == HOLD_MAX);
  assign bad_stable  = (bad_cnt == HOLD_MAX);

endmodule

// File: rtl/fdu_failover_ctrl.sv
// rtl/fdu_failover_ctrl.sv - selects a healthy FDU, fails over and sequences restarts
module fdu_failover_ctrl
  import fdu_pkg::*;
#(
  parameter int NUM_FDU         = 2,
  parameter int HOLDOFF         = 16,
  parameter int RESTART_CYCLES  = 1000,
  parameter int STARTUP_TIMEOUT = 13000000,
  parameter int MAX_RETRY       = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [NUM_FDU-1:0]           health,
  output logic                         active_valid,
  output logic [$clog2(NUM_FDU)-1:0]   active_sel,
  output logic [NUM_FDU-1:0]           fdu_restart,
  output logic [RETRY_CNT_W-1:0]       retry_cnt,
  output logic [FAILOVER_CNT_W-1:0]    failover_cnt,
  output logic                         all_failed
);

  localparam int SEL_W = $clog2(NUM_FDU);
  localparam int TW    = $clog2(STARTUP_TIMEOUT + 1);
  localparam logic [TW-1:0]          TIMER_LAST  = TW'(STARTUP_TIMEOUT - 1);
  localparam logic [RETRY_CNT_W-1:0] RETRY_LIMIT = RETRY_CNT_W'(MAX_RETRY);

  fdu_state_e                state, state_nxt;
  logic [SEL_W-1:0]          sel_nxt;
  logic [TW-1:0]             timer, timer_nxt;
  logic [RETRY_CNT_W-1:0]    retry_nxt;
  logic [FAILOVER_CNT_W-1:0] fo_nxt;

  logic [NUM_FDU-1:0] good_stable;
  logic [NUM_FDU-1:0] bad_stable;
  logic [NUM_FDU-1:0] restarting;
  logic [NUM_FDU-1:0] restart_req;
  logic [NUM_FDU-1:0] eligible;
  logic               any_eligible;
  logic [SEL_W-1:0]   low_idx;
  logic               search_timeout;

  for (genvar g = 0; g < NUM_FDU; g++) begin : g_lane
    fdu_lane_mon #(
      .HOLDOFF        (HOLDOFF),
      .RESTART_CYCLES (RESTART_CYCLES)
    ) u_mon (
      .clk         (clk),
      .reset_n     (reset_n),
      .health      (health[g]),
      .restart_req (restart_req[g]),
      .good_stable (good_stable[g]),
      .bad_stable  (bad_stable[g]),
      .restarting  (restarting[g]),
      .fdu_restart (fdu_restart[g])
    );
  end

  assign eligible       = good_stable & ~restarting;
  assign any_eligible   = |eligible;
  assign search_timeout = (timer == TIMER_LAST);

  // Priority pick: lowest-numbered eligible lane wins
  always_comb begin
    low_idx = '0;
    for (int i = NUM_FDU - 1; i >= 0; i--) begin
      if (eligible[i]) low_idx = SEL_W'(i);
    end
  end

  // State register with the search timer and the externally visible counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      active_sel   <= '0;
      timer        <= '0;
      retry_cnt    <= '0;
      failover_cnt <= '0;
    end else begin
      state        <= state_nxt;
      active_sel   <= sel_nxt;
      timer        <= timer_nxt;
      retry_cnt    <= retry_nxt;
      failover_cnt <= fo_nxt;
    end
  end

  // Next state: eligibility beats the search timeout; enable low always wins
  always_comb begin
    state_nxt = state;
    sel_nxt   = active_sel;
    timer_nxt = timer;
    retry_nxt = retry_cnt;
    fo_nxt    = failover_cnt;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_SEARCH;
          timer_nxt = '0;
        end
        ST_SEARCH: begin
          if (any_eligible) begin
            state_nxt = ST_ACTIVE;
            sel_nxt   = low_idx;
            retry_nxt = '0;
          end else if (search_timeout) begin
            if (retry_cnt == RETRY_LIMIT) begin
              state_nxt = ST_FAILED;
            end else begin
              retry_nxt = retry_cnt + RETRY_CNT_W'(1);
              timer_nxt = '0;
            end
          end else begin
            timer_nxt = timer + TW'(1);
          end
        end
        ST_ACTIVE: begin
          if (bad_stable[active_sel]) begin
            state_nxt = ST_SEARCH;
            fo_nxt    = sat_inc_fo(failover_cnt);
            timer_nxt = '0;
          end
        end
        default: begin
          state_nxt = ST_FAILED;
        end
      endcase
    end
  end

  // Outputs: status flags from state, restart requests on failover or on a fruitless search round
  always_comb begin
    active_valid = (state == ST_ACTIVE);
    all_failed   = (state == ST_FAILED);
    restart_req  = '0;
    if (enable) begin
      if (state == ST_SEARCH && !any_eligible && search_timeout && retry_cnt != RETRY_LIMIT) begin
        restart_req = ~good_stable & ~restarting;
      end else if (state == ST_ACTIVE && bad_stable[active_sel]) begin
        restart_req[active_sel] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fdu_failover_ctrl.sv
// tb/tb_fdu_failover_ctrl.sv - self-checking bench for fdu_failover_ctrl
module tb_fdu_failover_ctrl;

  localparam int NUM             = 2;
  localparam int HOLDOFF         = 4;
  localparam int RESTART_CYCLES  = 8;
  localparam int STARTUP_TIMEOUT = 50;
  localparam int MAX_RETRY       = 2;

  localparam int M_IDLE   = 0;
  localparam int M_SEARCH = 1;
  localparam int M_ACTIVE = 2;
  localparam int M_FAILED = 3;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           enable = 1'b0;
  logic [NUM-1:0] health = '0;
  logic           active_valid;
  logic [0:0]     active_sel;
  logic [NUM-1:0] fdu_restart;
  logic [3:0]     retry_cnt;
  logic [7:0]     failover_cnt;
  logic           all_failed;
  logic [16:0]    dut_vec;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state: run lengths, remaining restart cycles, mode, counters
  int m_hi[NUM];
  int m_lo[NUM];
  int m_rst[NUM];
  int m_state, m_sel, m_timer, m_retry, m_fo;

  fdu_failover_ctrl #(
    .NUM_FDU(NUM), .HOLDOFF(HOLDOFF), .RESTART_CYCLES(RESTART_CYCLES),
    .STARTUP_TIMEOUT(STARTUP_TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .health(health),
    .active_valid(active_valid), .active_sel(active_sel), .fdu_restart(fdu_restart),
    .retry_cnt(retry_cnt), .failover_cnt(failover_cnt), .all_failed(all_failed)
  );

  assign dut_vec = {active_valid, active_sel, fdu_restart, retry_cnt, failover_cnt, all_failed};

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  task automatic model_reset();
    for (int i = 0; i < NUM; i++) begin
      m_hi[i] = 0; m_lo[i] = 0; m_rst[i] = 0;
    end
    m_state = M_IDLE; m_sel = 0; m_timer = 0; m_retry = 0; m_fo = 0;
  endtask

  function automatic logic [16:0] model_out();
    logic [NUM-1:0] r;
    logic           av, af;
    logic [0:0]     s;
    logic [3:0]     rc;
    logic [7:0]     fc;
    for (int i = 0; i < NUM; i++) r[i] = (m_rst[i] > 0);
    av = (m_state == M_ACTIVE);
    af = (m_state == M_FAILED);
    s  = 1'(m_sel);
    rc = 4'(m_retry);
    fc = 8'(m_fo);
    return {av, s, r, rc, fc, af};
  endfunction

  // one clock edge: decide from pre-edge inputs, then let the edge happen, then commit
  task automatic tick();
    int ns, nsel, ntimer, nretry, nfo, found;
    bit req[NUM];
    bit was;
    logic [NUM-1:0] h;
    h = health;
    ns = m_state; nsel = m_sel; ntimer = m_timer; nretry = m_retry; nfo = m_fo;
    for (int i = 0; i < NUM; i++) req[i] = 0;
    if (!enable) begin
      ns = M_IDLE;
    end else if (m_state == M_IDLE) begin
      ns = M_SEARCH; ntimer = 0;
    end else if (m_state == M_SEARCH) begin
      found = -1;
      for (int i = NUM - 1; i >= 0; i--)
        if (m_hi[i] >= HOLDOFF && m_rst[i] == 0) found = i;
      if (found >= 0) begin
        ns = M_ACTIVE; nsel = found; nretry = 0;
      end else if (m_timer == STARTUP_TIMEOUT - 1) begin
        if (m_retry == MAX_RETRY) ns = M_FAILED;
        else begin
          for (int i = 0; i < NUM; i++)
            if (m_hi[i] < HOLDOFF && m_rst[i] == 0) req[i] = 1;
          nretry = m_retry + 1; ntimer = 0;
        end
      end else begin
        ntimer = m_timer + 1;
      end
    end else if (m_state == M_ACTIVE) begin
      if (m_lo[m_sel] >= HOLDOFF) begin
        ns = M_SEARCH; ntimer = 0; req[m_sel] = 1;
        if (nfo < 255) nfo = nfo + 1;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM; i++) begin
      was = (m_rst[i] > 0);
      if (was) m_rst[i] = m_rst[i] - 1;
      else if (req[i]) m_rst[i] = RESTART_CYCLES;
      if (was || req[i]) begin
        m_hi[i] = 0; m_lo[i] = 0;
      end else if (h[i]) begin
        m_hi[i] = m_hi[i] + 1; m_lo[i] = 0;
      end else begin
        m_lo[i] = m_lo[i] + 1; m_hi[i] = 0;
      end
    end
    m_state = ns; m_sel = nsel; m_timer = ntimer; m_retry = nretry; m_fo = nfo;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; health = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (dut_vec !== 17'h0) begin
      n_fail++; $display("FAIL reset_values got=%h exp=%h", dut_vec, 17'h0);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_acquire();
    enable = 1'b1; health = 2'b11;
    repeat (4) begin
      tick();
      n_tests++;
      if (dut_vec !== model_out()) begin
        n_fail++; $display("FAIL acquire_model got=%h exp=%h", dut_vec, model_out());
      end
    end
    n_tests++;
    if (active_valid !== 1'b0) begin
      n_fail++; $display("FAIL acquire_early got=%b exp=0", active_valid);
    end
    tick();
    n_tests++;
    if (active_valid !== 1'b1 || active_sel !== 1'b0) begin
      n_fail++; $display("FAIL acquire_latency got=%b/%0d exp=1/0", active_valid, active_sel);
    end
  endtask

  task automatic test_glitch();
    health = 2'b10;
    repeat (3) tick();
    health = 2'b11;
    repeat (8) begin
      tick();
      n_tests++;
      if (dut_vec !== model_out()) begin
        n_fail++; $display("FAIL glitch_model got=%h exp=%h", dut_vec, model_out());
      end
    end
    n_tests++;
    if (failover_cnt !== 8'd0 || active_valid !== 1'b1 || active_sel !== 1'b0) begin
      n_fail++; $display("FAIL glitch_no_failover got=%0d/%b exp=0/1", failover_cnt, active_valid);
    end
  endtask

  task automatic test_failover();
    int rcount;
    health = 2'b10;
    repeat (4) tick();
    n_tests++;
    if (active_valid !== 1'b1) begin
      n_fail++; $display("FAIL failover_early got=%b exp=1", active_valid);
    end
    tick();
    n_tests++;
    if (active_valid !== 1'b0 || failover_cnt !== 8'd1 || fdu_restart !== 2'b01) begin
      n_fail++; $display("FAIL failover_edge got=%b/%0d/%b exp=0/1/01", active_valid, failover_cnt, fdu_restart);
    end
    rcount = 1;
    repeat (20) begin
      tick();
      n_tests++;
      if (dut_vec !== model_out()) begin
        n_fail++; $display("FAIL failover_model got=%h exp=%h", dut_vec, model_out());
      end
      if (fdu_restart[0] === 1'b1) rcount++;
    end
    n_tests++;
    if (rcount != RESTART_CYCLES) begin
      n_fail++; $display("FAIL restart_width got=%0d exp=%0d", rcount, RESTART_CYCLES);
    end
    n_tests++;
    if (active_valid !== 1'b1 || active_sel !== 1'b1) begin
      n_fail++; $display("FAIL failover_new_active got=%b/%0d exp=1/1", active_valid, active_sel);
    end
  endtask

  task automatic test_all_failed();
    bit seen_round;
    int k;
    seen_round = 0;
    health = 2'b00;
    k = 0;
    while (all_failed !== 1'b1 && k < 400) begin
      tick();
      k++;
      n_tests++;
      if (dut_vec !== model_out()) begin
        n_fail++; $display("FAIL allfail_model got=%h exp=%h", dut_vec, model_out());
      end
      if (!seen_round && retry_cnt === 4'd1) begin
        seen_round = 1;
        n_tests++;
        if (fdu_restart !== 2'b11) begin
          n_fail++; $display("FAIL round_restart got=%b exp=11", fdu_restart);
        end
      end
    end
    n_tests++;
    if (!seen_round || all_failed !== 1'b1 || retry_cnt !== 4'd2) begin
      n_fail++; $display("FAIL all_failed_reached got=%b/%0d exp=1/2", all_failed, retry_cnt);
    end
    repeat (30) begin
      tick();
      n_tests++;
      if (fdu_restart !== 2'b00 || all_failed !== 1'b1) begin
        n_fail++; $display("FAIL failed_quiet got=%b/%b exp=00/1", fdu_restart, all_failed);
      end
    end
  endtask

  task automatic test_recover();
    int k;
    enable = 1'b0; health = 2'b01;
    tick();
    n_tests++;
    if (all_failed !== 1'b0 || active_valid !== 1'b0 || dut_vec !== model_out()) begin
      n_fail++; $display("FAIL recover_idle got=%h exp=%h", dut_vec, model_out());
    end
    enable = 1'b1;
    k = 0;
    while (active_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    n_tests++;
    if (active_valid !== 1'b1 || active_sel !== 1'b0 || retry_cnt !== 4'd0) begin
      n_fail++; $display("FAIL recover_active got=%b/%0d/%0d exp=1/0/0", active_valid, active_sel, retry_cnt);
    end
  endtask

  task automatic test_reset_mid_restart();
    health = 2'b10;
    repeat (5) tick();
    n_tests++;
    if (fdu_restart[0] !== 1'b1) begin
      n_fail++; $display("FAIL mid_restart_setup got=%b exp=1", fdu_restart[0]);
    end
    repeat (2) tick();
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (dut_vec !== 17'h0) begin
      n_fail++; $display("FAIL async_reset got=%h exp=%h", dut_vec, 17'h0);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    enable = 1'b1;
    health = 2'b11;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM; i++)
        if ($urandom_range(11, 0) == 0) health[i] = ~health[i];
      enable = ($urandom_range(199, 0) != 0);
      tick();
      n_tests++;
      if (dut_vec !== model_out()) begin
        n_fail++; $display("FAIL random_model cyc=%0d got=%h exp=%h", c, dut_vec, model_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_glitch();
    test_failover();
    test_all_failed();
    test_recover();
    test_reset_mid_restart();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
